// File: rtl/dadda_signed_mult_ctrl.sv
// rtl/dadda_signed_mult_ctrl.sv - valid/ready signed/unsigned wrapper around a 32x32 carry-save multiplier core
// The core is purely combinational; the wrapper holds its operands in registers until the product is captured.

module dadda_multiplier (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] product
);
    // Partial products are compressed with rows of 3:2 counters until two rows remain.
    function automatic logic [63:0] csa_tree(input logic [31:0] x, input logic [31:0] y);
        logic [63:0] rows [32];
        logic [63:0] nxt  [32];
        int n;
        int m;
        for (int i = 0; i < 32; i++) begin
            rows[i] = y[i] ? (64'(x) << i) : 64'd0;
        end
        n = 32;
        for (int s = 0; s < 8; s++) begin
            if (n > 2) begin
                m = 0;
                for (int i = 0; i < 32; i++) begin
                    nxt[i] = 64'd0;
                end
                for (int i = 0; i < 30; i += 3) begin
                    if (i + 2 < n) begin
                        nxt[5'(m)]     = rows[i] ^ rows[i+1] ^ rows[i+2];
                        nxt[5'(m + 1)] = ((rows[i] & rows[i+1]) | (rows[i] & rows[i+2])
                                        | (rows[i+1] & rows[i+2])) << 1;
                        m = m + 2;
                    end
                end
                for (int i = 0; i < 32; i++) begin
                    if (i >= n - (n % 3) && i < n) begin
                        nxt[5'(m)] = rows[i];
                        m = m + 1;
                    end
                end
                for (int i = 0; i < 32; i++) begin
                    rows[i] = nxt[i];
                end
                n = m;
            end
        end
        return rows[0] + rows[1];
    endfunction

    assign product = csa_tree(a, b);
endmodule

module dadda_signed_mult_ctrl #(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t               state;
    state_t               state_next;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic                 neg;
    logic [3:0]           cnt;
    logic [2*WIDTH-1:0]   core_product;
    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;

    // Negating 2^31 in 32 bits yields 2^31 again, which is the correct unsigned magnitude.
    assign abs_a = (signed_mode && a[WIDTH-1]) ? -a : a;
    assign abs_b = (signed_mode && b[WIDTH-1]) ? -b : b;

    dadda_multiplier u_core (
        .a       (mag_a),
        .b       (mag_b),
        .product (core_product)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = MUL;
            MUL:     if (cnt == 4'd0) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            mag_a   <= '0;
            mag_b   <= '0;
            neg     <= 1'b0;
            cnt     <= 4'd0;
            product <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && in_valid) begin
                mag_a <= abs_a;
                mag_b <= abs_b;
                neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                cnt   <= 4'(SETTLE_CYCLES - 1);
            end
            if (state == MUL) begin
                if (cnt == 4'd0) begin
                    product <= neg ? -core_product : core_product;
                end else begin
                    cnt <= cnt - 4'd1;
                end
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
endmodule

// File: tb/tb_dadda_signed_mult_ctrl.sv
// tb/tb_dadda_signed_mult_ctrl.sv - scoreboard bench for dadda_signed_mult_ctrl at SETTLE_CYCLES 1 and 4

module tb_dadda_signed_mult_ctrl;
    localparam int S0 = 1;
    localparam int S1 = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid    [2];
    logic        in_ready    [2];
    logic        signed_mode [2];
    logic        out_valid   [2];
    logic        out_ready   [2];
    logic        busy        [2];
    logic [31:0] a           [2];
    logic [31:0] b           [2];
    logic [63:0] product     [2];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    typedef struct {
        logic [63:0] val;
        int          acc;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic        prev_v [2];
    logic [63:0] cur    [2];
    bit          rand_ready1 = 1'b0;

    dadda_signed_mult_ctrl #(.WIDTH(32), .SETTLE_CYCLES(S0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .signed_mode(signed_mode[0]), .a(a[0]), .b(b[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .product(product[0]), .busy(busy[0])
    );

    dadda_signed_mult_ctrl #(.WIDTH(32), .SETTLE_CYCLES(S1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .signed_mode(signed_mode[1]), .a(a[1]), .b(b[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .product(product[1]), .busy(busy[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic sm, input logic [31:0] x, input logic [31:0] y);
        longint sx;
        longint sy;
        if (sm) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            return 64'(sx * sy);
        end
        return {32'd0, x} * {32'd0, y};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'($urandom_range(0, 20)) - 32'd10;
            default: return $urandom;
        endcase
    endfunction

    // Called at a falling edge; returns at the falling edge after the accepting edge.
    task automatic issue(input int k, input logic sm, input logic [31:0] x, input logic [31:0] y,
                         input logic [63:0] e);
        int   w;
        exp_t it;
        w = 0;
        in_valid[k]    = 1'b1;
        signed_mode[k] = sm;
        a[k]           = x;
        b[k]           = y;
        while (!in_ready[k] && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready[k]) begin
            chk($sformatf("accept_timeout%0d", k), 64'd0, 64'd1);
            in_valid[k] = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid[k] = 1'b0;
        it.val = e;
        it.acc = cyc;
        if (k == 0) q0.push_back(it);
        else        q1.push_back(it);
    endtask

    task automatic mon(input int k);
        exp_t e;
        int   s;
        bit   empty;
        s = (k == 0) ? S0 : S1;
        if (rst) begin
            prev_v[k] = 1'b0;
            return;
        end
        if (out_valid[k] && !prev_v[k]) begin
            empty = (k == 0) ? (q0.size() == 0) : (q1.size() == 0);
            if (empty) begin
                chk($sformatf("unexpected_out_valid%0d", k), 64'd1, 64'd0);
            end else begin
                if (k == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                cur[k] = e.val;
                chk($sformatf("product%0d", k), product[k], e.val);
                chk($sformatf("latency%0d", k), 64'(cyc - e.acc), 64'(s));
            end
        end else if (out_valid[k]) begin
            chk($sformatf("held_product%0d", k), product[k], cur[k]);
        end
        if (out_valid[k]) chk($sformatf("in_ready_in_done%0d", k), 64'(in_ready[k]), 64'd0);
        prev_v[k] = out_valid[k];
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) mon(k);
    end

    always @(negedge clk) begin
        if (rand_ready1) out_ready[1] = ($urandom_range(0, 3) != 0);
    end

    task automatic drain();
        int w;
        w = 0;
        while ((q0.size() != 0 || q1.size() != 0 || out_valid[0] || out_valid[1]) && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 2000) chk("drain_timeout", 64'd0, 64'd1);
    endtask

    task automatic chk_idle(input int k, input string tag);
        chk($sformatf("%s_in_ready%0d", tag, k), 64'(in_ready[k]), 64'd1);
        chk($sformatf("%s_out_valid%0d", tag, k), 64'(out_valid[k]), 64'd0);
        chk($sformatf("%s_product%0d", tag, k), product[k], 64'd0);
        chk($sformatf("%s_busy%0d", tag, k), 64'(busy[k]), 64'd0);
    endtask

    initial begin
        int w;
        logic        sm;
        logic [31:0] x;
        logic [31:0] y;
        for (int k = 0; k < 2; k++) begin
            in_valid[k]    = 1'b0;
            signed_mode[k] = 1'b0;
            a[k]           = 32'd0;
            b[k]           = 32'd0;
            out_ready[k]   = 1'b1;
            prev_v[k]      = 1'b0;
            cur[k]         = 64'd0;
        end
        #2;
        chk_idle(0, "reset");
        chk_idle(1, "reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        issue(0, 1'b1, 32'd12345, 32'd67890, 64'd838102050);
        issue(0, 1'b1, -32'sd9876, 32'd12345, -64'sd121919220);
        issue(0, 1'b1, -32'sd12345, -32'sd67890, 64'd838102050);
        issue(0, 1'b1, 32'd9876, -32'sd12345, -64'sd121919220);
        issue(0, 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        issue(0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        issue(0, 1'b1, 32'd0, -32'sd5, 64'd0);
        drain();

        // Backpressure: result must stay put while operands wiggle.
        out_ready[0] = 1'b0;
        issue(0, 1'b1, -32'sd7, 32'd9, -64'sd63);
        w = 0;
        while (!out_valid[0] && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("bp_out_valid_rise", 64'(out_valid[0]), 64'd1);
        for (int i = 0; i < 5; i++) begin
            a[0]           = $urandom;
            b[0]           = $urandom;
            signed_mode[0] = 1'($urandom_range(0, 1));
            chk("bp_in_ready", 64'(in_ready[0]), 64'd0);
            chk("bp_out_valid", 64'(out_valid[0]), 64'd1);
            @(negedge clk);
        end
        out_ready[0] = 1'b1;
        @(negedge clk);
        chk("bp_release_out_valid", 64'(out_valid[0]), 64'd0);
        chk("bp_release_in_ready", 64'(in_ready[0]), 64'd1);
        drain();

        // Reset while the operation is in flight.
        in_valid[0]    = 1'b1;
        signed_mode[0] = 1'b1;
        a[0]           = 32'd100;
        b[0]           = 32'd200;
        @(posedge clk);
        #1;
        chk("mid_busy", 64'(busy[0]), 64'd1);
        rst         = 1'b1;
        in_valid[0] = 1'b0;
        #1;
        chk_idle(0, "midrst");
        @(negedge clk);
        rst = 1'b0;
        issue(0, 1'b1, 32'd3, -32'sd4, -64'sd12);
        drain();

        // Back-to-back random traffic on both instances, random backpressure on the slow one.
        rand_ready1 = 1'b1;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    sm = 1'($urandom_range(0, 1));
                    x  = pick();
                    y  = pick();
                    issue(1, sm, x, y, ref_mul(sm, x, y));
                end
            end
            begin
                for (int i = 0; i < 30; i++) begin
                    sm = 1'($urandom_range(0, 1));
                    x  = pick();
                    y  = pick();
                    issue(0, sm, x, y, ref_mul(sm, x, y));
                end
            end
        join
        drain();
        rand_ready1  = 1'b0;
        out_ready[1] = 1'b1;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
